// File: rtl/key_poll_master.sv
// Purpose: Avalon-MM read initiator that polls the key PIO data register,
//          debounces bit 0 and reports a clean level plus press/release pulses.
// Latency: sample taken READ_LATENCY cycles after each strobe; level/pulse one cycle later.
// Backpressure: none; the slave has no waitrequest, so every strobe completes.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   poll_enable       polling runs while high (an in-flight read always finishes)
//   avm_address       constant 0 (PIO data register)
//   avm_read          one-cycle read strobe every POLL_DIV cycles
//   avm_readdata      slave read data, only bit 0 is used
//   key_level         debounced level, 1 = pressed
//   key_pressed       one-cycle pulse on a debounced 0->1 transition
//   key_released      one-cycle pulse on a debounced 1->0 transition
//   sample_valid      one-cycle pulse in the cycle a raw sample is taken
module key_poll_master #(
    parameter int POLL_DIV       = 50000,
    parameter int READ_LATENCY   = 1,
    parameter int DEBOUNCE_COUNT = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        poll_enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        key_level,
    output logic        key_pressed,
    output logic        key_released,
    output logic        sample_valid
);

    localparam int DW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WAIT   = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] div;
    logic [LW-1:0] wait_cnt;
    logic [CW-1:0] db_cnt;
    logic [CW:0]   cnt_inc;
    logic          stable;
    logic          raw;

    // Upper read-data bits carry nothing for a single-bit PIO.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:1];

    assign avm_address = 2'b00;
    assign key_level   = stable;
    assign raw         = avm_readdata[0] ^ KEY_ACTIVE_LOW;
    assign cnt_inc     = {1'b0, db_cnt} + 1'b1;

    // Poll divider: free-runs 0..POLL_DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (!poll_enable) begin
            div <= '0;
        end else if (div == DW'(POLL_DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            // WAIT is entered with the count already at 1 (first cycle after the strobe).
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= LW'(1);
            end
        end
    end

    // READ is entered one cycle ahead so that it coincides with divider == POLL_DIV-1.
    // The strobe is still gated by poll_enable in that cycle, so dropping enable
    // exactly on the strobe cycle suppresses the read and returns to IDLE.
    always_comb begin
        state_next   = state;
        avm_read     = 1'b0;
        sample_valid = 1'b0;
        case (state)
            IDLE: begin
                if (poll_enable && (div == DW'(POLL_DIV - 2))) begin
                    state_next = READ;
                end
            end
            READ: begin
                avm_read = poll_enable;
                if (!poll_enable) begin
                    state_next = IDLE;
                end else if (READ_LATENCY == 1) begin
                    state_next = SAMPLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == LW'(READ_LATENCY - 1)) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Debounce: a run of DEBOUNCE_COUNT consecutive differing samples flips the
    // stable level; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable       <= 1'b0;
            db_cnt       <= '0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
        end else begin
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
            if (sample_valid) begin
                if (raw == stable) begin
                    db_cnt <= '0;
                end else if (cnt_inc == (CW + 1)'(DEBOUNCE_COUNT)) begin
                    stable       <= raw;
                    db_cnt       <= '0;
                    key_pressed  <= raw;
                    key_released <= ~raw;
                end else begin
                    db_cnt <= cnt_inc[CW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_key_poll_master.sv
module tb_key_poll_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        poll_enable;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        key_level;
    logic        key_pressed;
    logic        key_released;
    logic        sample_valid;

    int checks = 0;
    int errors = 0;

    key_poll_master #(
        .POLL_DIV      (4),
        .READ_LATENCY  (1),
        .DEBOUNCE_COUNT(3),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .poll_enable (poll_enable),
        .avm_address (avm_address),
        .avm_read    (avm_read),
        .avm_readdata(avm_readdata),
        .key_level   (key_level),
        .key_pressed (key_pressed),
        .key_released(key_released),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    // Holds reset across two edges and releases it mid-cycle; on return the
    // bench sits in cycle 0 (divider 0, before the first post-reset edge).
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        poll_enable  = 1'b1;
        avm_readdata = 32'h0000_0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL reset_avm_read got %b exp 0", avm_read); end
        checks++; if (avm_address !== 2'b00) begin errors++; $display("FAIL reset_avm_address got %b exp 00", avm_address); end
        checks++; if (key_level !== 1'b0) begin errors++; $display("FAIL reset_key_level got %b exp 0", key_level); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_key_pressed got %b exp 0", key_pressed); end
        checks++; if (key_released !== 1'b0) begin errors++; $display("FAIL reset_key_released got %b exp 0", key_released); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %b exp 0", sample_valid); end
    endtask

    task automatic test_strobe();
        poll_enable  = 1'b1;
        avm_readdata = 32'hFFFF_FFFF;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            #1;
            checks++; if (avm_read !== ((c % 4) == 3)) begin errors++; $display("FAIL strobe_read c=%0d got %b exp %b", c, avm_read, ((c % 4) == 3)); end
            checks++; if (sample_valid !== ((c % 4) == 0 && c > 0)) begin errors++; $display("FAIL strobe_sample c=%0d got %b exp %b", c, sample_valid, ((c % 4) == 0 && c > 0)); end
            checks++; if (avm_address !== 2'b00) begin errors++; $display("FAIL strobe_address c=%0d got %b exp 00", c, avm_address); end
            checks++; if (key_level !== 1'b0) begin errors++; $display("FAIL strobe_level c=%0d got %b exp 0", c, key_level); end
            @(negedge clk);
        end
    endtask

    task automatic test_clean_press();
        poll_enable  = 1'b1;
        avm_readdata = 32'hFFFF_FFFF;
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            avm_readdata = (c >= 3) ? 32'h0000_0000 : 32'hFFFF_FFFF;
            #1;
            checks++; if (key_pressed !== (c == 13)) begin errors++; $display("FAIL press_pulse c=%0d got %b exp %b", c, key_pressed, (c == 13)); end
            checks++; if (key_level !== (c >= 13)) begin errors++; $display("FAIL press_level c=%0d got %b exp %b", c, key_level, (c >= 13)); end
            checks++; if (key_released !== 1'b0) begin errors++; $display("FAIL press_released c=%0d got %b exp 0", c, key_released); end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce();
        // Sample k (taken at cycle 4k+4) sees pattern bit k; 1 = pressed.
        logic [6:0] pat;
        int         n_press;
        pat          = 7'b1111011;  // LSB first: P P R P P P P
        n_press      = 0;
        poll_enable  = 1'b1;
        avm_readdata = 32'hFFFF_FFFF;
        do_reset();
        for (int c = 0; c <= 28; c++) begin
            if (c >= 1) begin
                avm_readdata = pat[(c - 1) / 4] ? 32'h0000_0000 : 32'h0000_0001;
            end
            #1;
            if (key_pressed === 1'b1) n_press++;
            checks++; if (key_pressed !== (c == 25)) begin errors++; $display("FAIL bounce_pulse c=%0d got %b exp %b", c, key_pressed, (c == 25)); end
            checks++; if (key_level !== (c >= 25)) begin errors++; $display("FAIL bounce_level c=%0d got %b exp %b", c, key_level, (c >= 25)); end
            @(negedge clk);
        end
        checks++; if (n_press !== 1) begin errors++; $display("FAIL bounce_pulse_count got %0d exp 1", n_press); end
    endtask

    task automatic test_release_upper();
        int n_rel;
        n_rel        = 0;
        poll_enable  = 1'b1;
        avm_readdata = 32'hFFFF_FFFF;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if (c <= 12)      avm_readdata = 32'h0000_0000;
            else if (c <= 24) avm_readdata = 32'hFFFF_FFFE;
            else              avm_readdata = 32'hFFFF_FFFF;
            #1;
            if (key_released === 1'b1) n_rel++;
            checks++; if (key_level !== (c >= 13 && c < 37)) begin errors++; $display("FAIL release_level c=%0d got %b exp %b", c, key_level, (c >= 13 && c < 37)); end
            checks++; if (key_released !== (c == 37)) begin errors++; $display("FAIL release_pulse c=%0d got %b exp %b", c, key_released, (c == 37)); end
            checks++; if (key_pressed !== (c == 13)) begin errors++; $display("FAIL release_pressed c=%0d got %b exp %b", c, key_pressed, (c == 13)); end
            checks++; if ((key_pressed & key_released) !== 1'b0) begin errors++; $display("FAIL release_both_pulses c=%0d got 1 exp 0", c); end
            @(negedge clk);
        end
        checks++; if (n_rel !== 1) begin errors++; $display("FAIL release_pulse_count got %0d exp 1", n_rel); end
    endtask

    task automatic test_poll_drop();
        poll_enable  = 1'b1;
        avm_readdata = 32'hFFFF_FFFF;
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            poll_enable = !(c >= 4 && c <= 9);
            #1;
            checks++; if (avm_read !== (c == 3 || c == 13 || c == 17)) begin errors++; $display("FAIL drop_read c=%0d got %b exp %b", c, avm_read, (c == 3 || c == 13 || c == 17)); end
            checks++; if (sample_valid !== (c == 4 || c == 14 || c == 18)) begin errors++; $display("FAIL drop_sample c=%0d got %b exp %b", c, sample_valid, (c == 4 || c == 14 || c == 18)); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        poll_enable  = 1'b1;
        avm_readdata = 32'h0000_0000;
        do_reset();
        // Two pressed samples land at cycles 4 and 8; stop in strobe cycle 11.
        for (int c = 0; c <= 10; c++) begin
            #1;
            checks++; if (key_level !== 1'b0) begin errors++; $display("FAIL mid_pre_level c=%0d got %b exp 0", c, key_level); end
            @(negedge clk);
        end
        #1;
        checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL mid_strobe_before_reset got %b exp 1", avm_read); end
        reset = 1'b1;
        #1;
        checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL mid_async_read got %b exp 0", avm_read); end
        checks++; if (key_level !== 1'b0) begin errors++; $display("FAIL mid_async_level got %b exp 0", key_level); end
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            #1;
            checks++; if (key_pressed !== (c == 13)) begin errors++; $display("FAIL mid_post_pulse c=%0d got %b exp %b", c, key_pressed, (c == 13)); end
            checks++; if (key_level !== (c >= 13)) begin errors++; $display("FAIL mid_post_level c=%0d got %b exp %b", c, key_level, (c >= 13)); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_clean_press();
        test_bounce();
        test_release_upper();
        test_poll_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_poll_master.md
Name: key_poll_master

Overview:
- Avalon-MM read initiator for the single-bit key input PIO slave.
- Polls the PIO data register (address 0) at a fixed rate and captures readdata[0] after the slave's fixed read latency.
- Debounces the samples and presents a clean key level plus one-cycle press and release pulses to the display/measurement control logic.
- Needs no CPU involvement; it sits on the PIO slave port in place of, or arbitrated alongside, the Nios data master.

Parameters:
- POLL_DIV, 50000: clock cycles between successive read strobes; legal range is READ_LATENCY+2 or more.
- READ_LATENCY, 1: cycles from the read strobe to valid readdata. The slave registers readdata, so this is fixed at 1 for the target PIO; 1 to 4 are legal.
- DEBOUNCE_COUNT, 4: consecutive samples that must differ from the stable level before that level changes; legal range 1 to 255.
- KEY_ACTIVE_LOW, 1: 1 means readdata[0]=0 is "pressed".

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- poll_enable  in  1  when 1, polling runs
- avm_address  out  2  Avalon address; constant 0
- avm_read  out  1  read strobe, one cycle wide
- avm_readdata  in  32  slave read data; only bit 0 is used
- key_level  out  1  debounced level, 1 = pressed
- key_pressed  out  1  one-cycle pulse on a debounced 0->1 transition
- key_released  out  1  one-cycle pulse on a debounced 1->0 transition
- sample_valid  out  1  one-cycle pulse in the cycle a raw sample is taken

Behaviour:
- Reset (asynchronous, active-high): every output is 0, including avm_address. The divider, latency pipe, debounce counter and stable level are all cleared (stable = released).
- Divider:
  - counts 0..POLL_DIV-1 and wraps, only while poll_enable=1;
  - poll_enable=0 holds it at 0.
- Read strobe:
  - avm_read=1 exactly in the cycle R where the divider equals POLL_DIV-1 and poll_enable=1;
  - otherwise avm_read=0;
  - the slave has no waitrequest, so every strobe completes.
- Latency pipe: a READ_LATENCY-deep shift register of strobes.
  - In cycle R+READ_LATENCY, sample_valid=1 and raw = avm_readdata[0] XOR KEY_ACTIVE_LOW.
  - Bits 31:1 of avm_readdata are ignored.
  - Deasserting poll_enable does not cancel an in-flight read; its sample is still taken.
- Debounce, evaluated only when sample_valid=1:
  - raw == stable: counter resets to 0.
  - raw != stable and counter+1 < DEBOUNCE_COUNT: counter increments.
  - raw != stable and counter+1 == DEBOUNCE_COUNT: stable takes raw, counter resets to 0, and the matching pulse is scheduled.
  - The counter width holds DEBOUNCE_COUNT; it never wraps.
- Output timing:
  - key_level follows stable.
  - key_pressed or key_released is high for exactly one cycle, R+READ_LATENCY+1, the same cycle key_level first shows the new value.
  - Both pulses are never high together.
- DEBOUNCE_COUNT=1: a single differing sample flips the level.
- State machine: IDLE (divider counting) -> READ (one cycle) -> WAIT (READ_LATENCY-1 cycles) -> SAMPLE (one cycle) -> IDLE.
  - With POLL_DIV at or above its minimum, reads never overlap.
- Reset mid-operation (during WAIT or mid-debounce): the pending sample and partial count are discarded, key_level returns to 0, and no pulse is emitted.

Test Plan:
- Address/strobe: POLL_DIV=4, READ_LATENCY=1 -> after reset release, avm_read=1 in cycles 3, 7, 11, ..., never two consecutive cycles; avm_address=0 always.
- Clean press: DEBOUNCE_COUNT=3, slave returns readdata=0 (active low) from cycle 3 onward -> samples at cycles 4, 8, 12; key_level=1 and key_pressed=1 in cycle 13 only; key_released stays 0.
- Bounce rejection: samples pressed, pressed, released, pressed, pressed -> counter resets on the third sample; key_level stays 0 until the third consecutive pressed sample; exactly one key_pressed pulse.
- Release and upper bits: from pressed state, readdata=32'hFFFF_FFFF (bit 0 = 1) for 3 samples -> key_level=0 and a single key_released pulse; repeat with readdata=32'hFFFF_FFFE -> no change, since only bit 0 is used.
- poll_enable drop: deassert poll_enable in the cycle after a strobe -> that sample is still taken (sample_valid=1 one cycle later), then no further avm_read; on re-enable, the first strobe arrives POLL_DIV-1 cycles later.
- Reset mid-debounce: assert reset after 2 of 3 pressed samples -> all outputs 0 immediately (asynchronous); after release, 3 fresh pressed samples are needed before key_pressed fires.
